// File: rtl/matrix_framebuf.sv
// matrix_framebuf: double-buffered RGB444 frame store for the HUB75 driver.
// The writer fills the back bank while the driver scans the front bank. Each
// read returns one BCM bit-plane of an upper/lower pixel pair after two cycles.
// Banks swap only at a driver frame boundary, so the display never tears.

// One panel half: a two-bank pixel RAM, its registered read port and the
// bit-plane select stage. The top instantiates one per half.
module matrix_framebuf_half #(
    parameter int AW      = 11,
    parameter int BPC     = 4,
    parameter int PL_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [3*BPC-1:0]   wr_data,
    input  logic               re,
    input  logic [AW-1:0]      rd_addr,
    input  logic               sel_en,
    input  logic [PL_BITS-1:0] sel_plane,
    output logic [2:0]         rgb_q
);
    localparam int DEPTH = 1 << AW;

    logic [3*BPC-1:0] mem [DEPTH];
    logic [3*BPC-1:0] rd_word;
    logic [BPC-1:0]   ch_r, ch_g, ch_b;

    // RAM: write port and registered read port; contents are never cleared
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        if (re)
            rd_word <= mem[rd_addr];
    end

    assign ch_r = rd_word[3*BPC-1:2*BPC];
    assign ch_g = rd_word[2*BPC-1:BPC];
    assign ch_b = rd_word[BPC-1:0];

    // Plane select stage; holds its value when no read completes
    always_ff @(posedge clk) begin
        if (rst)
            rgb_q <= '0;
        else if (sel_en)
            rgb_q <= {ch_r[sel_plane], ch_g[sel_plane], ch_b[sel_plane]};
    end
endmodule

module matrix_framebuf #(
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 4,
    parameter int BPC      = 4,
    parameter int PL_BITS  = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [COL_BITS-1:0]   wr_x,
    input  logic [ROW_BITS:0]     wr_y,
    input  logic [3*BPC-1:0]      wr_rgb,
    input  logic                  wr_frame_done,
    output logic                  swap_pending,
    output logic                  front_buf,
    input  logic                  frame_start,
    input  logic                  rd_req,
    input  logic [COL_BITS-1:0]   rd_col,
    input  logic [ROW_BITS-1:0]   rd_row,
    input  logic [PL_BITS-1:0]    rd_plane,
    output logic                  rd_valid,
    output logic [2:0]            rd_rgb0,
    output logic [2:0]            rd_rgb1
);
    localparam int AW     = COL_BITS + ROW_BITS + 1;
    localparam int STAGES = 2;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t               state, state_nxt;
    logic                 do_swap;
    logic                 wr_fire;
    logic [1:0]           half_we;
    logic [AW-1:0]        wr_addr, rd_addr;
    logic [STAGES:1]      vld_pipe;
    logic [PL_BITS-1:0]   plane_q;
    logic [1:0][2:0]      rgb_q;

    // Swap FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Swap FSM: a request waits for frame_start; extra requests while waiting are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (wr_frame_done && !frame_start) state_nxt = S_PENDING;
            S_PENDING: if (frame_start)                   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Swap FSM outputs: a request coinciding with frame_start swaps immediately
    always_comb begin
        swap_pending = (state == S_PENDING);
        do_swap      = frame_start && ((state == S_PENDING) || wr_frame_done);
    end

    // Front bank index toggles on the edge that ends the frame_start cycle
    always_ff @(posedge clk) begin
        if (rst)
            front_buf <= 1'b0;
        else if (do_swap)
            front_buf <= ~front_buf;
    end

    // Writer is stalled while a swap waits, so the finished frame stays intact
    assign wr_ready = ~swap_pending & ~rst;
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_addr  = {~front_buf, wr_y[ROW_BITS-1:0], wr_x};
    assign half_we  = {wr_fire & wr_y[ROW_BITS], wr_fire & ~wr_y[ROW_BITS]};

    // The bank is sampled with the request, so in-flight reads survive a swap
    assign rd_addr  = {front_buf, rd_row, rd_col};

    // Read valid pipe; reset flushes anything in flight
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], rd_req};
    end

    // Bit-plane index travels alongside its request
    always_ff @(posedge clk) begin
        if (rd_req)
            plane_q <= rd_plane;
    end

    for (genvar h = 0; h < 2; h++) begin : g_half
        matrix_framebuf_half #(
            .AW      (AW),
            .BPC     (BPC),
            .PL_BITS (PL_BITS)
        ) u_half (
            .clk       (clk),
            .rst       (rst),
            .we        (half_we[h]),
            .wr_addr   (wr_addr),
            .wr_data   (wr_rgb),
            .re        (rd_req),
            .rd_addr   (rd_addr),
            .sel_en    (vld_pipe[1]),
            .sel_plane (plane_q),
            .rgb_q     (rgb_q[h])
        );
    end

    assign rd_valid = vld_pipe[STAGES];
    assign rd_rgb0  = rgb_q[0];
    assign rd_rgb1  = rgb_q[1];
endmodule

// File: tb/tb_matrix_framebuf.sv
// Randomised and directed bench for matrix_framebuf against a frame-level model.
module tb_matrix_framebuf;
    localparam int COL_BITS = 6;
    localparam int ROW_BITS = 4;
    localparam int BPC      = 4;
    localparam int NPIX     = 1 << (COL_BITS + ROW_BITS);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [COL_BITS-1:0] wr_x = '0;
    logic [ROW_BITS:0]   wr_y = '0;
    logic [3*BPC-1:0]    wr_rgb = '0;
    logic                wr_frame_done = 1'b0;
    logic                swap_pending;
    logic                front_buf;
    logic                frame_start = 1'b0;
    logic                rd_req = 1'b0;
    logic [COL_BITS-1:0] rd_col = '0;
    logic [ROW_BITS-1:0] rd_row = '0;
    logic [1:0]          rd_plane = '0;
    logic                rd_valid;
    logic [2:0]          rd_rgb0, rd_rgb1;

    matrix_framebuf #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .BPC(BPC)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .wr_frame_done(wr_frame_done),
        .swap_pending(swap_pending), .front_buf(front_buf), .frame_start(frame_start),
        .rd_req(rd_req), .rd_col(rd_col), .rd_row(rd_row), .rd_plane(rd_plane),
        .rd_valid(rd_valid), .rd_rgb0(rd_rgb0), .rd_rgb1(rd_rgb1)
    );

    always #5 clk = ~clk;

    // Reference model: frame contents per bank/half, front bank, swap request flag
    typedef struct { int due; logic [2:0] r0; logic [2:0] r1; } exp_t;
    int         mmem [2][2][NPIX];
    bit         mfront, mpend;
    int         ecnt;
    exp_t       q[$];
    logic [2:0] last0, last1;
    int         n_tests, n_fail;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] plane_bits(input int w, input int p);
        logic [2:0] b;
        b[2] = ((w >> (2*BPC + p)) & 1) != 0;
        b[1] = ((w >> (BPC + p)) & 1) != 0;
        b[0] = ((w >> p) & 1) != 0;
        return b;
    endfunction

    // One clock: update the model with the inputs seen at the edge, then check outputs
    task automatic cyc();
        exp_t e;
        bit   exp_v;
        int   a;
        @(posedge clk);
        ecnt++;
        if (rst) begin
            mfront = 0; mpend = 0; q.delete(); last0 = '0; last1 = '0;
        end else begin
            if (wr_valid && !mpend)
                mmem[!mfront][wr_y[ROW_BITS]][(int'(wr_y[ROW_BITS-1:0]) << COL_BITS) | int'(wr_x)] = int'(wr_rgb);
            if (rd_req) begin
                a     = (int'(rd_row) << COL_BITS) | int'(rd_col);
                e.due = ecnt + 1;
                e.r0  = plane_bits(mmem[mfront][0][a], int'(rd_plane));
                e.r1  = plane_bits(mmem[mfront][1][a], int'(rd_plane));
                q.push_back(e);
            end
            if (frame_start && (mpend || wr_frame_done)) begin
                mfront = !mfront; mpend = 0;
            end else if (wr_frame_done) begin
                mpend = 1;
            end
        end
        #1;
        exp_v = (q.size() > 0) && (q[0].due == ecnt);
        if (exp_v) begin
            e = q.pop_front();
            last0 = e.r0; last1 = e.r1;
        end
        chk("rd_valid", int'(rd_valid), int'(exp_v));
        chk("rd_rgb0", int'(rd_rgb0), int'(last0));
        chk("rd_rgb1", int'(rd_rgb1), int'(last1));
        chk("front_buf", int'(front_buf), int'(mfront));
        chk("swap_pending", int'(swap_pending), int'(mpend));
        chk("wr_ready", int'(wr_ready), int'(!mpend && !rst));
    endtask

    task automatic do_write(input int x, input int y, input int rgb);
        bit acc = 0;
        wr_valid = 1; wr_x = COL_BITS'(x); wr_y = (ROW_BITS+1)'(y); wr_rgb = (3*BPC)'(rgb);
        for (int n = 0; n < 64; n++) begin
            #1;
            acc = wr_ready;
            cyc();
            if (acc) break;
        end
        wr_valid = 0;
        if (!acc) chk("wr_accept_timeout", 0, 1);
    endtask

    task automatic read_req(input int x, input int row, input int p);
        rd_req = 1; rd_col = COL_BITS'(x); rd_row = ROW_BITS'(row); rd_plane = 2'(p);
    endtask

    task automatic swap_now();
        wr_frame_done = 1; frame_start = 1;
        cyc();
        wr_frame_done = 0; frame_start = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit f0;
        logic [2:0] old0;
        n_tests = 0; n_fail = 0; ecnt = 0;
        last0 = '0; last1 = '0;

        // T1: reset held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_front", int'(front_buf), 0);
            chk("t1_pend", int'(swap_pending), 0);
            chk("t1_rd_valid", int'(rd_valid), 0);
            chk("t1_wr_ready", int'(wr_ready), 0);
        end
        rst = 0;
        cyc();
        chk("t1_wr_ready_after", int'(wr_ready), 1);

        // Fill both banks so every later read has a known value
        for (int pass = 0; pass < 2; pass++) begin
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 64; x++)
                    do_write(x, y, int'($urandom_range(0, 4095)));
            swap_now();
        end

        // T2: data path and plane select
        do_write(5, 3, 'hA5C);
        do_write(5, 19, 'h3F0);
        wr_frame_done = 1; cyc(); wr_frame_done = 0;
        chk("t2_pend", int'(swap_pending), 1);
        f0 = front_buf;
        frame_start = 1; cyc(); frame_start = 0;
        chk("t2_swapped", int'(front_buf), int'(!f0));
        read_req(5, 3, 0); cyc();
        chk("t2_lat_not_yet", int'(rd_valid), 0);
        read_req(5, 3, 3); cyc();
        rd_req = 0;
        chk("t2_p0_valid", int'(rd_valid), 1);
        chk("t2_p0_rgb0", int'(rd_rgb0), 'b010);
        chk("t2_p0_rgb1", int'(rd_rgb1), 'b110);
        cyc();
        chk("t2_p3_rgb0", int'(rd_rgb0), 'b101);
        chk("t2_p3_rgb1", int'(rd_rgb1), 'b010);
        cyc();
        chk("t2_hold_rgb0", int'(rd_rgb0), 'b101);

        // T3: tear-free, back-buffer write invisible until frame_start
        old0 = plane_bits(mmem[mfront][0][0], 0);
        do_write(0, 0, 'hFFF);
        wr_frame_done = 1; cyc(); wr_frame_done = 0;
        for (int i = 0; i < 4; i++) begin
            read_req(0, 0, 0); cyc();
        end
        rd_req = 0;
        chk("t3_old_frame", int'(rd_rgb0), int'(old0));
        frame_start = 1; cyc(); frame_start = 0;
        read_req(0, 0, 0); cyc(); rd_req = 0; cyc();
        chk("t3_new_frame", int'(rd_rgb0), 'b111);

        // T4: backpressure while swap pending
        wr_frame_done = 1; cyc(); wr_frame_done = 0;
        wr_valid = 1; wr_x = 7; wr_y = 20; wr_rgb = 'h123;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_stalled", int'(wr_ready), 0);
            cyc();
        end
        frame_start = 1;
        #1 chk("t4_stalled_fs", int'(wr_ready), 0);
        cyc(); frame_start = 0;
        chk("t4_ready", int'(wr_ready), 1);
        cyc(); wr_valid = 0;
        swap_now();
        read_req(7, 4, 1); cyc(); rd_req = 0; cyc();
        chk("t4_held_pixel", int'(rd_rgb1), 'b011);

        // T5: frame done and frame start in the same cycle
        f0 = front_buf;
        wr_frame_done = 1; frame_start = 1;
        #1 chk("t5_no_pend_before", int'(swap_pending), 0);
        cyc(); wr_frame_done = 0; frame_start = 0;
        chk("t5_toggled", int'(front_buf), int'(!f0));
        chk("t5_no_pend", int'(swap_pending), 0);

        // T6: 64 back-to-back reads, then reset mid-stream
        cnt = 0;
        for (int i = 0; i < 66; i++) begin
            if (i < 64) read_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            else rd_req = 0;
            cyc();
            if (rd_valid) cnt++;
        end
        chk("t6_stream_count", cnt, 64);
        wr_frame_done = 1; cyc(); wr_frame_done = 0;
        for (int i = 0; i < 10; i++) begin
            read_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            cyc();
        end
        rst = 1; cyc();
        chk("t6_rst_valid", int'(rd_valid), 0);
        chk("t6_rst_pend", int'(swap_pending), 0);
        chk("t6_rst_front", int'(front_buf), 0);
        rst = 0; rd_req = 0;
        cyc(); cyc();
        chk("t6_flushed", int'(rd_valid), 0);

        // Random mix of reads, writes, swaps and occasional reset
        for (int i = 0; i < 3000; i++) begin
            rd_req        = $urandom_range(0, 1) != 0;
            rd_col        = COL_BITS'($urandom);
            rd_row        = ROW_BITS'($urandom);
            rd_plane      = 2'($urandom);
            wr_valid      = $urandom_range(0, 1) != 0;
            wr_x          = COL_BITS'($urandom);
            wr_y          = (ROW_BITS+1)'($urandom);
            wr_rgb        = (3*BPC)'($urandom);
            wr_frame_done = $urandom_range(0, 39) == 0;
            frame_start   = $urandom_range(0, 29) == 0;
            rst           = $urandom_range(0, 499) == 0;
            cyc();
        end
        rst = 0; rd_req = 0; wr_valid = 0; wr_frame_done = 0; frame_start = 0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
